// File: rtl/mouse_param_ctrl.sv
// Mouse-driven multi-channel parameter adjuster with hold-off auto-repeat.
// Also tracks pointer drag offset inside the chart window.
module mouse_param_ctrl #(
    parameter int NUM_CH   = 3,
    parameter int VAL_W    = 12,
    parameter int POS_W    = 12,
    parameter int REGION_W = 300,
    parameter int HOLDOFF  = 100000,
    parameter int COARSE   = 10,
    parameter int MIN_VAL  = 0,
    parameter int MAX_VAL  = 4095,
    parameter int INIT_VAL = 2048,
    parameter int DRAG_X0  = 32,
    parameter int DRAG_Y0  = 32,
    parameter int DRAG_W   = 960,
    parameter int DRAG_H   = 480,
    localparam int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    left_mouse,
    input  logic                    right_mouse,
    input  logic                    middle_mouse,
    input  logic [POS_W-1:0]        xpos,
    input  logic [POS_W-1:0]        ypos,
    output logic [NUM_CH*VAL_W-1:0] values,
    output logic [SEL_W-1:0]        sel_ch,
    output logic                    update,
    output logic                    busy,
    output logic [POS_W-1:0]        drag_dx,
    output logic [POS_W-1:0]        drag_dy,
    output logic                    drag_neg_x,
    output logic                    drag_neg_y,
    output logic                    drag_active
);

    localparam int CNT_W = $clog2(HOLDOFF + 1);
    localparam int SW    = VAL_W + 2;

    localparam logic [31:0] WX0 = 32'(DRAG_X0);
    localparam logic [31:0] WX1 = 32'(DRAG_X0 + DRAG_W);
    localparam logic [31:0] WY0 = 32'(DRAG_Y0);
    localparam logic [31:0] WY1 = 32'(DRAG_Y0 + DRAG_H);

    localparam logic signed [SW-1:0] MIN_S = SW'(MIN_VAL);
    localparam logic signed [SW-1:0] MAX_S = SW'(MAX_VAL);
    localparam logic [CNT_W-1:0]     LAST  = CNT_W'(HOLDOFF - 1);
    localparam logic [VAL_W-1:0]     INIT  = VAL_W'(INIT_VAL);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       x32;
    logic [31:0]       y32;
    logic              in_win;
    logic              ch_hit;
    logic [SEL_W-1:0]  ch_idx;
    logic              go;
    logic [VAL_W-1:0]  cur;
    logic signed [SW-1:0] step;
    logic signed [SW-1:0] sum;
    logic [VAL_W-1:0]  nxt;
    logic [POS_W-1:0]  anchor_x;
    logic [POS_W-1:0]  anchor_y;

    assign x32 = 32'(xpos);
    assign y32 = 32'(ypos);
    assign in_win = (x32 >= WX0) && (x32 <= WX1) &&
                    (y32 >= WY0) && (y32 <= WY1);

    // Region decode as a compare chain against fixed boundaries.
    always_comb begin
        ch_hit = 1'b0;
        ch_idx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (x32 >= 32'(k * REGION_W) &&
                x32 < 32'((k + 1) * REGION_W)) begin
                ch_hit = 1'b1;
                ch_idx = SEL_W'(k);
            end
        end
    end

    assign go = (left_mouse ^ right_mouse) && ch_hit && !in_win;

    always_comb begin
        cur  = values[int'(ch_idx)*VAL_W +: VAL_W];
        step = middle_mouse ? SW'(COARSE) : SW'(1);
        sum  = left_mouse ? $signed({2'b00, cur}) - step
                          : $signed({2'b00, cur}) + step;
        if (sum > MAX_S)      nxt = VAL_W'(MAX_S);
        else if (sum < MIN_S) nxt = VAL_W'(MIN_S);
        else                  nxt = VAL_W'(sum);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            values <= {NUM_CH{INIT}};
            sel_ch <= '0;
            update <= 1'b0;
            busy   <= 1'b0;
        end else begin
            update <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (go) begin
                        values[int'(ch_idx)*VAL_W +: VAL_W] <= nxt;
                        sel_ch <= ch_idx;
                        update <= 1'b1;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Anchor follows the pointer outside the window; offsets hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            anchor_x    <= '0;
            anchor_y    <= '0;
            drag_dx     <= '0;
            drag_dy     <= '0;
            drag_neg_x  <= 1'b0;
            drag_neg_y  <= 1'b0;
            drag_active <= 1'b0;
        end else if (!in_win) begin
            anchor_x    <= xpos;
            anchor_y    <= ypos;
            drag_active <= 1'b0;
        end else if (left_mouse) begin
            drag_dx     <= (xpos >= anchor_x) ? xpos - anchor_x
                                              : anchor_x - xpos;
            drag_dy     <= (ypos >= anchor_y) ? ypos - anchor_y
                                              : anchor_y - ypos;
            drag_neg_x  <= (anchor_x >= xpos);
            drag_neg_y  <= (anchor_y >= ypos);
            drag_active <= 1'b1;
        end else begin
            drag_active <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mouse_param_ctrl.sv
// Scoreboard bench for mouse_param_ctrl: stimulus pushes expected updates,
// a negedge monitor pops and compares whenever update pulses.
module tb_mouse_param_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        left_mouse;
    logic        right_mouse;
    logic        middle_mouse;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic [35:0] values;
    logic [1:0]  sel_ch;
    logic        update;
    logic        busy;
    logic [11:0] drag_dx;
    logic [11:0] drag_dy;
    logic        drag_neg_x;
    logic        drag_neg_y;
    logic        drag_active;

    typedef struct packed {
        logic [1:0]  ch;
        logic [35:0] v;
    } exp_t;

    exp_t q[$];
    int   nvec  = 0;
    int   nfail = 0;
    logic prev_upd = 1'b0;

    always #5 clk = ~clk;

    mouse_param_ctrl #(
        .HOLDOFF(4),
        .MIN_VAL(2000),
        .MAX_VAL(2050)
    ) dut (
        .clk(clk),
        .rst(rst),
        .left_mouse(left_mouse),
        .right_mouse(right_mouse),
        .middle_mouse(middle_mouse),
        .xpos(xpos),
        .ypos(ypos),
        .values(values),
        .sel_ch(sel_ch),
        .update(update),
        .busy(busy),
        .drag_dx(drag_dx),
        .drag_dy(drag_dy),
        .drag_neg_x(drag_neg_x),
        .drag_neg_y(drag_neg_y),
        .drag_active(drag_active)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input int ch, input int v0, input int v1,
                        input int v2);
        exp_t e;
        e.ch = 2'(ch);
        e.v  = {12'(v2), 12'(v1), 12'(v0)};
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pack3(input int v0, input int v1,
                                          input int v2);
        return 64'({12'(v2), 12'(v1), 12'(v0)});
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (update === 1'b1) begin
            chk("upd_gap", 64'(prev_upd), 64'd0);
            if (q.size() == 0) begin
                nvec++;
                nfail++;
                $display("FAIL upd_unexpected: got ch %0d val %h expected none",
                         sel_ch, values);
            end else begin
                e = q.pop_front();
                chk("upd_ch", 64'(sel_ch), 64'(e.ch));
                chk("upd_val", 64'(values), 64'(e.v));
            end
        end
        prev_upd = (update === 1'b1);
    end

    initial begin
        logic [10:0] mask;
        int bc;
        int cnt;
        rst = 1'b1;
        left_mouse = 1'b0;
        right_mouse = 1'b0;
        middle_mouse = 1'b0;
        xpos = 12'd0;
        ypos = 12'd600;
        tick();
        tick();
        chk("rst_values", 64'(values), pack3(2048, 2048, 2048));
        chk("rst_sel", 64'(sel_ch), 64'd0);
        chk("rst_update", 64'(update), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_drag", 64'({drag_dx, drag_dy, drag_neg_x, drag_neg_y,
                             drag_active}), 64'd0);
        rst = 1'b0;
        xpos = 12'd350;
        tick();

        // single fine step up on channel 1, re-press during hold ignored
        right_mouse = 1'b1;
        push(1, 2048, 2049, 2048);
        tick();
        right_mouse = 1'b0;
        bc = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy) bc++;
            if (i == 1) right_mouse = 1'b1;
            if (i == 2) right_mouse = 1'b0;
            tick();
        end
        chk("busy_cycles", 64'(bc), 64'd4);

        // coarse auto-repeat down on channel 0
        xpos = 12'd100;
        left_mouse = 1'b1;
        middle_mouse = 1'b1;
        push(0, 2038, 2049, 2048);
        push(0, 2028, 2049, 2048);
        push(0, 2018, 2049, 2048);
        mask = '0;
        for (int i = 0; i < 11; i++) begin
            tick();
            mask[i] = update;
        end
        left_mouse = 1'b0;
        middle_mouse = 1'b0;
        chk("repeat_mask", 64'(mask), 64'b10000100001);
        repeat (5) tick();
        chk("ch0_2018", 64'(values), pack3(2018, 2049, 2048));

        // continue down into MIN_VAL clamp
        left_mouse = 1'b1;
        middle_mouse = 1'b1;
        push(0, 2008, 2049, 2048);
        push(0, 2000, 2049, 2048);
        push(0, 2000, 2049, 2048);
        mask = '0;
        for (int i = 0; i < 11; i++) begin
            tick();
            mask[i] = update;
        end
        left_mouse = 1'b0;
        middle_mouse = 1'b0;
        chk("min_mask", 64'(mask), 64'b10000100001);
        repeat (5) tick();

        // MAX_VAL clamp on channel 2
        xpos = 12'd650;
        right_mouse = 1'b1;
        middle_mouse = 1'b1;
        push(2, 2000, 2049, 2050);
        tick();
        right_mouse = 1'b0;
        middle_mouse = 1'b0;
        repeat (5) tick();
        right_mouse = 1'b1;
        push(2, 2000, 2049, 2050);
        tick();
        right_mouse = 1'b0;
        repeat (5) tick();
        chk("max_clamp", 64'(values), pack3(2000, 2049, 2050));

        // rejected steps: both buttons, off-region, inside window
        cnt = 0;
        xpos = 12'd350;
        left_mouse = 1'b1;
        right_mouse = 1'b1;
        repeat (4) begin tick(); cnt += int'(update) + int'(busy); end
        left_mouse = 1'b0;
        xpos = 12'd950;
        repeat (4) begin tick(); cnt += int'(update) + int'(busy); end
        xpos = 12'd400;
        ypos = 12'd100;
        repeat (4) begin tick(); cnt += int'(update) + int'(busy); end
        right_mouse = 1'b0;
        chk("no_step", 64'(cnt), 64'd0);
        chk("no_change", 64'(values), pack3(2000, 2049, 2050));

        // drag tracking
        xpos = 12'd10;
        ypos = 12'd10;
        tick();
        xpos = 12'd100;
        ypos = 12'd50;
        left_mouse = 1'b1;
        tick();
        chk("drag_dx", 64'(drag_dx), 64'd90);
        chk("drag_dy", 64'(drag_dy), 64'd40);
        chk("drag_neg", 64'({drag_neg_x, drag_neg_y}), 64'd0);
        chk("drag_act", 64'(drag_active), 64'd1);
        left_mouse = 1'b0;
        tick();
        chk("drag_rel", 64'({drag_active, drag_dx, drag_dy}),
            64'({1'b0, 12'd90, 12'd40}));
        xpos = 12'd600;
        ypos = 12'd600;
        tick();
        xpos = 12'd500;
        ypos = 12'd400;
        left_mouse = 1'b1;
        tick();
        chk("drag_neg_d", 64'({drag_dx, drag_dy}), 64'({12'd100, 12'd200}));
        chk("drag_neg_f", 64'({drag_neg_x, drag_neg_y, drag_active}),
            64'b111);
        left_mouse = 1'b0;
        tick();

        // reset during hold-off
        xpos = 12'd350;
        ypos = 12'd600;
        right_mouse = 1'b1;
        push(1, 2000, 2050, 2050);
        tick();
        right_mouse = 1'b0;
        chk("hold_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        chk("rst_hold_busy", 64'(busy), 64'd0);
        chk("rst_hold_vals", 64'(values), pack3(2048, 2048, 2048));
        rst = 1'b0;
        tick();
        chk("post_rst_busy", 64'(busy), 64'd0);
        tick();
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
